// File: rtl/sensor_conditioner_pkg.sv
// Shared bridge-sensor definitions: debounce default, sensor numbering and
// limit-switch roles, and the debounce counter width.
package sensor_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int NUM_SENSORS             = 6;

  localparam int S1_IDX = 0;
  localparam int S2_IDX = 1;
  localparam int S3_IDX = 2;
  localparam int S4_IDX = 3;
  localparam int S5_IDX = 4;
  localparam int S6_IDX = 5;

  // The deck limit switches are mutually exclusive in a healthy bridge.
  localparam int DECK_UP_IDX   = S5_IDX;
  localparam int DECK_DOWN_IDX = S6_IDX;

  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sensor_conditioner_debounce_channel.sv
// One sensor channel: 2-flop synchronizer, saturating debounce counter,
// accepted level and a one-cycle change strobe aligned with the level update.
module debounce_channel
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic change
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          syn;
  logic [CW-1:0] cnt;

  // NOTE: every register here uses non-blocking assignment so the
  // synchronizer stages and counter all see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      syn    <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      change <= 1'b0;
    end else begin
      meta <= raw;
      syn  <= meta;
      if (syn == level) begin
        cnt    <= '0;
        change <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        // Acceptance point: take the new level and restart instead of wrapping.
        level  <= syn;
        cnt    <= '0;
        change <= 1'b1;
      end else begin
        cnt    <= cnt + CW'(1);
        change <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Six debounced bridge sensors with a merged change pulse and a sticky
// deck-limit conflict flag.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic r1,
  input  logic r2,
  input  logic r3,
  input  logic r4,
  input  logic r5,
  input  logic r6,
  input  logic clear,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic s6,
  output logic chg,
  output logic flt
);

  logic [NUM_SENSORS-1:0] raw;
  logic [NUM_SENSORS-1:0] level;
  logic [NUM_SENSORS-1:0] strobe;

  assign raw = {r6, r5, r4, r3, r2, r1};

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .level (level[i]),
      .change(strobe[i])
    );
  end

  assign s1 = level[S1_IDX];
  assign s2 = level[S2_IDX];
  assign s3 = level[S3_IDX];
  assign s4 = level[S4_IDX];
  assign s5 = level[S5_IDX];
  assign s6 = level[S6_IDX];

  // Strobes are registered per channel, so the OR is already a clean pulse.
  assign chg = |strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt <= 1'b0;
    end else if (level[DECK_UP_IDX] && level[DECK_DOWN_IDX]) begin
      flt <= 1'b1;
    end else if (clear) begin
      flt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Scoreboard bench for sensor_conditioner with DEBOUNCE_CYCLES = 4.
module tb_sensor_conditioner;

  logic       clk;
  logic       rst_n;
  logic [5:0] r;
  logic       clear;
  logic       s1, s2, s3, s4, s5, s6, chg, flt;
  logic [7:0] obs;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  sensor_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .r1   (r[0]),
    .r2   (r[1]),
    .r3   (r[2]),
    .r4   (r[3]),
    .r5   (r[4]),
    .r6   (r[5]),
    .clear(clear),
    .s1   (s1),
    .s2   (s2),
    .s3   (s3),
    .s4   (s4),
    .s5   (s5),
    .s6   (s6),
    .chg  (chg),
    .flt  (flt)
  );

  assign obs = {flt, chg, s6, s5, s4, s3, s2, s1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ev(input logic [5:0] s, input logic c, input logic f);
    return {f, c, s};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {flt,chg,s6..s1}=%b expected %b", tag, got, exp);
  endtask

  // Push the expectation for the coming edge, then compare on the falling edge.
  task automatic tick(input string tag, input logic [7:0] e);
    exp_t x;
    sb.push_back('{tag, e});
    @(posedge clk);
    @(negedge clk);
    x = sb.pop_front();
    check(x.tag, obs, x.val);
  endtask

  task automatic ticks(input int n, input string tag, input logic [7:0] e);
    for (int i = 0; i < n; i++) tick($sformatf("%s@%0d", tag, i + 1), e);
  endtask

  task automatic reset_pulse(input string tag, input logic [5:0] r_after);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check(tag, obs, 8'h00);
    r = r_after;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    r     = 6'b0;
    clear = 1'b0;
    #1 check("reset_state", obs, 8'h00);
    #11 rst_n = 1'b1;
    ticks(3, "idle", 8'h00);

    // All sensors high, then an asynchronous reset between edges.
    r = 6'b111111;
    ticks(5, "all_hi_wait", 8'h00);
    tick("all_hi_accept", ev(6'b111111, 1'b1, 1'b0));
    tick("all_hi_flt", ev(6'b111111, 1'b0, 1'b1));
    reset_pulse("async_reset_all", 6'b0);
    ticks(3, "post_reset_idle", 8'h00);

    // Single channel rise and fall.
    r = 6'b000100;
    ticks(5, "r3_wait", 8'h00);
    tick("r3_accept", ev(6'b000100, 1'b1, 1'b0));
    tick("r3_hold", ev(6'b000100, 1'b0, 1'b0));
    r = 6'b000000;
    ticks(5, "r3_fall_wait", ev(6'b000100, 1'b0, 1'b0));
    tick("r3_fall", ev(6'b000000, 1'b1, 1'b0));
    tick("r3_fall_hold", 8'h00);

    // Glitch shorter than the debounce window is rejected.
    r = 6'b000010;
    ticks(3, "r2_glitch", 8'h00);
    r = 6'b000000;
    ticks(20, "r2_reject", 8'h00);

    // Limit-switch conflict: set, set-wins over clear, sticky, then clear.
    r = 6'b110000;
    ticks(5, "lim_wait", 8'h00);
    tick("lim_accept", ev(6'b110000, 1'b1, 1'b0));
    tick("flt_set", ev(6'b110000, 1'b0, 1'b1));
    clear = 1'b1;
    tick("clear_blocked", ev(6'b110000, 1'b0, 1'b1));
    clear = 1'b0;
    r = 6'b010000;
    ticks(5, "r6_fall_wait", ev(6'b110000, 1'b0, 1'b1));
    tick("r6_fall", ev(6'b010000, 1'b1, 1'b1));
    tick("flt_sticky", ev(6'b010000, 1'b0, 1'b1));
    clear = 1'b1;
    tick("flt_clear", ev(6'b010000, 1'b0, 1'b0));
    clear = 1'b0;
    tick("flt_cleared", ev(6'b010000, 1'b0, 1'b0));
    r = 6'b000000;
    ticks(5, "r5_fall_wait", ev(6'b010000, 1'b0, 1'b0));
    tick("r5_fall", ev(6'b000000, 1'b1, 1'b0));
    tick("r5_fall_hold", 8'h00);

    // Reset mid-debounce discards the partial count.
    r = 6'b000001;
    ticks(3, "r1_partial", 8'h00);
    reset_pulse("reset_mid_debounce", 6'b000001);
    tick("no_chg_first_edge", 8'h00);
    ticks(4, "r1_restart_wait", 8'h00);
    tick("r1_accept", ev(6'b000001, 1'b1, 1'b0));
    tick("r1_hold", ev(6'b000001, 1'b0, 1'b0));
    r = 6'b000000;
    ticks(5, "r1_fall_wait", ev(6'b000001, 1'b0, 1'b0));
    tick("r1_fall", ev(6'b000000, 1'b1, 1'b0));
    tick("r1_fall_hold", 8'h00);

    // Simultaneous acceptance on three channels gives one CHG pulse.
    r = 6'b101001;
    ticks(5, "multi_wait", 8'h00);
    tick("multi_accept", ev(6'b101001, 1'b1, 1'b0));
    tick("multi_single_pulse", ev(6'b101001, 1'b0, 1'b0));
    ticks(3, "multi_hold", ev(6'b101001, 1'b0, 1'b0));
    reset_pulse("reset_levels", 6'b0);
    ticks(2, "final_idle", 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive synchronized cycles a changed level must hold before it is accepted (legal range 2..15).
REQ-002 Clock  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 R1..R6  input  1 each  raw, asynchronous bridge sensor levels; R5 = deck-up limit, R6 = deck-down limit.
REQ-005 Clear  input  1  synchronous fault-clear request, level-sampled.
REQ-006 S1..S6  output  1 each  debounced sensor levels, consumed directly by the lowering/raising state machines.
REQ-007 CHG  output  1  one-cycle pulse when any of S1..S6 changes.
REQ-008 FLT  output  1  sticky limit-switch conflict flag.

Function
REQ-009 Each Rn SHALL pass through a 2-flop synchronizer; only the second-stage value (syn_n) is used downstream.
REQ-010 Each channel SHALL hold a counter of ceil(log2(DEBOUNCE_CYCLES)) bits, cleared on any edge where syn_n equals Sn.
REQ-011 Where syn_n differs from Sn, the counter SHALL increment; when it equals DEBOUNCE_CYCLES-1 and syn_n still differs, Sn SHALL take syn_n at that edge and the counter SHALL clear.
REQ-012 A raw level change held stable SHALL therefore appear on Sn exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-013 A raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never change Sn; any return to the current Sn value restarts the count from 0.
REQ-014 Counters SHALL never wrap: the count saturates at the acceptance point and clears.
REQ-015 Channels SHALL be fully independent; simultaneous acceptance on several channels in one cycle is legal.
REQ-016 CHG SHALL be 1 in the cycle after the edge on which at least one Sn changed, and 0 otherwise; simultaneous channel changes produce a single one-cycle pulse.
REQ-017 FLT SHALL set on the edge after S5 and S6 are both 1 and SHALL remain set regardless of later S5/S6 values.
REQ-018 FLT SHALL clear on an edge where Clear=1 and (S5 AND S6)=0; when Clear=1 and the conflict is present on the same edge, FLT SHALL stay 1 (set wins).
REQ-019 S1..S6 SHALL keep updating while FLT is set; FLT does not gate the sensors.

Reset
REQ-020 Reset=0 SHALL immediately, without a clock, force the synchronizer flops, all counters, S1..S6, CHG and FLT to 0.
REQ-021 Reset asserted mid-debounce SHALL discard the partial count; after release, a held raw level requires the full 2 + DEBOUNCE_CYCLES edges again.
REQ-022 The first edge after Reset release SHALL not produce CHG.

Structure
REQ-023 The shared bridge package SHALL hold DEBOUNCE_CYCLES default, sensor index constants (S1..S6 numbering, S5/S6 limit roles) and the counter-width calculation.
REQ-024 One sub-module, debounce_channel (synchronizer + counter + accepted level + change strobe), SHALL be instantiated six times; FLT and CHG logic SHALL reside in sensor_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 All Rn=1, Reset pulsed low asynchronously between edges -> S1..S6, CHG, FLT = 0 within the same timestep.
REQ-026 R3 0->1 held -> S3=1 after the 6th rising edge, CHG=1 for exactly the following cycle, other Sn unchanged.
REQ-027 R2 high for 3 cycles then low -> S2 stays 0 and CHG stays 0 for 20 cycles.
REQ-028 R5=R6=1 held -> S5,S6=1 after edge 6, FLT=1 after edge 7; R6 low -> FLT stays 1; Clear=1 while S5=S6=1 -> FLT stays 1; Clear=1 after S6=0 -> FLT=0 next edge.
REQ-029 R1=1 for 3 cycles, Reset pulse, R1 still 1 -> S1=1 only 6 edges after Reset release, CHG not asserted on the first post-reset edge.
REQ-030 R1, R4 and R6 rising on the same edge -> all three Sn rise on the same edge, single one-cycle CHG pulse.
